// File: rtl/y86_dmem_if.sv
// y86_dmem_if: core-side data-memory bus between the Y86 memory stage and y86_dmem.
//   mem_read   core read request
//   mem_write  core write request
//   mem_addr   byte address of the word LSB
//   mem_wdata  write data, little-endian word
//   mem_rdata  read data returned combinationally by the memory
// Modports: master = core side, slave = memory side.
interface y86_dmem_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_read,
    output mem_write,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/y86_dmem.sv
// y86_dmem: byte-addressed data memory for the Y86 memory stage.
// Reads are combinational so the core captures valM in the same cycle; writes and
// host byte loads commit on the clock edge. After reset an optional sweep zeroes
// every byte; the memory ignores all requests while that sweep runs.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   core          y86_dmem_if slave: read/write requests, address, write/read data
//   ld_valid_i    host byte-load strobe; ld_addr_i/ld_data_i give the byte and address
//   ld_ready_o    host load accepted this cycle (READY and no core write)
//   busy_o        high while the clear sweep runs
//   rd_count_o    saturating count of accepted core reads
//   wr_count_o    saturating count of accepted core writes
//   conflict_o    sticky: a read and a write were requested in the same READY cycle
module y86_dmem #(
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int CLEAR_ON_RESET = 1,
  parameter int CNT_W          = 16
) (
  input  logic              clk,
  input  logic              rst,
  y86_dmem_if.slave         core,
  input  logic              ld_valid_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [7:0]        ld_data_i,
  output logic              ld_ready_o,
  output logic              busy_o,
  output logic [CNT_W-1:0]  rd_count_o,
  output logic [CNT_W-1:0]  wr_count_o,
  output logic              conflict_o
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NBYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] PTR_LAST = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    READY = 1'b1
  } dmemState_t;

  dmemState_t        state_r;
  dmemState_t        stateNext_s;
  logic [ADDR_W-1:0] clrPtr_r;
  logic [7:0]        mem_r [DEPTH];
  logic              busy_s;
  logic              ldReady_s;
  logic              accept_s;
  logic [DATA_W-1:0] rdata_s;
  logic [CNT_W-1:0]  rdCount_r;
  logic [CNT_W-1:0]  wrCount_r;
  logic              conflict_r;

  // State register: reset chooses between the clear sweep and immediate service.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
    end else begin
      state_r <= stateNext_s;
    end
  end

  // Next-state logic: the cycle that clears the last byte hands over to READY.
  always_comb begin
    stateNext_s = state_r;
    case (state_r)
      CLEAR:   stateNext_s = (clrPtr_r == PTR_LAST) ? READY : CLEAR;
      READY:   stateNext_s = READY;
      default: stateNext_s = CLEAR;
    endcase
  end

  // Output decode: only READY accepts core requests; a core write blocks the host port.
  always_comb begin
    busy_s    = 1'b1;
    ldReady_s = 1'b0;
    accept_s  = 1'b0;
    case (state_r)
      CLEAR: begin
        busy_s    = 1'b1;
        ldReady_s = 1'b0;
        accept_s  = 1'b0;
      end
      READY: begin
        busy_s    = 1'b0;
        ldReady_s = ~core.mem_write;
        accept_s  = 1'b1;
      end
      default: begin
        busy_s    = 1'b1;
        ldReady_s = 1'b0;
        accept_s  = 1'b0;
      end
    endcase
  end

  // Combinational little-endian read; byte indices wrap at the top of memory.
  always_comb begin
    rdata_s = {DATA_W{1'b0}};
    if (accept_s && core.mem_read) begin
      for (int i = 0; i < NBYTES; i++) begin
        rdata_s[8*i +: 8] = mem_r[core.mem_addr + ADDR_W'(i)];
      end
    end else begin
      rdata_s = {DATA_W{1'b0}};
    end
  end

  // Clear pointer: restarts at zero on every reset, advances once per sweep cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      clrPtr_r <= {ADDR_W{1'b0}};
    end else if (state_r == CLEAR) begin
      clrPtr_r <= clrPtr_r + PTR_ONE;
    end else begin
      clrPtr_r <= clrPtr_r;
    end
  end

  // Array writes: sweep, core word write and host byte load. Contents survive reset;
  // core write and host load never coincide because a core write drops ld_ready.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_r == CLEAR) begin
        mem_r[clrPtr_r] <= 8'h00;
      end else begin
        if (core.mem_write) begin
          for (int i = 0; i < NBYTES; i++) begin
            mem_r[core.mem_addr + ADDR_W'(i)] <= core.mem_wdata[8*i +: 8];
          end
        end
        if (ld_valid_i && ldReady_s) begin
          mem_r[ld_addr_i] <= ld_data_i;
        end
      end
    end
  end

  // Saturating access counters and the sticky read/write conflict flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      rdCount_r  <= {CNT_W{1'b0}};
      wrCount_r  <= {CNT_W{1'b0}};
      conflict_r <= 1'b0;
    end else begin
      if (accept_s && core.mem_read && (rdCount_r != CNT_MAX)) begin
        rdCount_r <= rdCount_r + CNT_ONE;
      end
      if (accept_s && core.mem_write && (wrCount_r != CNT_MAX)) begin
        wrCount_r <= wrCount_r + CNT_ONE;
      end
      if (accept_s && core.mem_read && core.mem_write) begin
        conflict_r <= 1'b1;
      end
    end
  end

  assign core.mem_rdata = rdata_s;
  assign ld_ready_o     = ldReady_s;
  assign busy_o         = busy_s;
  assign rd_count_o     = rdCount_r;
  assign wr_count_o     = wrCount_r;
  assign conflict_o     = conflict_r;

endmodule

// File: tb/tb_y86_dmem.sv
// tb_y86_dmem: directed self-checking bench for y86_dmem.
module tb_y86_dmem;

  logic        clk = 1'b0;
  logic        rst;
  logic        ldValid;
  logic [7:0]  ldAddr;
  logic [7:0]  ldData;
  logic        ldReady;
  logic        busy;
  logic [15:0] rdCount;
  logic [15:0] wrCount;
  logic        conflict;

  int checks = 0;
  int failures = 0;
  int rdExp = 0;
  int wrExp = 0;
  int n;

  y86_dmem_if #(.ADDR_W(8), .DATA_W(32)) coreBus ();

  y86_dmem #(.ADDR_W(8), .DATA_W(32), .CLEAR_ON_RESET(1), .CNT_W(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .core       (coreBus),
    .ld_valid_i (ldValid),
    .ld_addr_i  (ldAddr),
    .ld_data_i  (ldData),
    .ld_ready_o (ldReady),
    .busy_o     (busy),
    .rd_count_o (rdCount),
    .wr_count_o (wrCount),
    .conflict_o (conflict)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    coreBus.mem_read  = 1'b0;
    coreBus.mem_write = 1'b0;
    coreBus.mem_addr  = 8'h00;
    coreBus.mem_wdata = 32'h0;
  endtask

  task automatic readChk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    coreBus.mem_read = 1'b1;
    coreBus.mem_addr = a;
    #1;
    checkVal(tag, coreBus.mem_rdata, exp);
    tick();
    coreBus.mem_read = 1'b0;
    rdExp++;
  endtask

  task automatic writeWord(input logic [7:0] a, input logic [31:0] d);
    coreBus.mem_write = 1'b1;
    coreBus.mem_addr  = a;
    coreBus.mem_wdata = d;
    tick();
    coreBus.mem_write = 1'b0;
    wrExp++;
  endtask

  // Counts cycles with busy high (bounded); optionally checks rdata stays 0 meanwhile.
  task automatic waitClear(input bit chkRd, output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      cnt++;
      if (chkRd) begin
        #1;
        checkVal("busyRdata", coreBus.mem_rdata, 32'h0);
      end
      tick();
    end
  endtask

  initial begin
    rst = 1'b1;
    ldValid = 1'b0;
    ldAddr = 8'h00;
    ldData = 8'h00;
    idle();
    repeat (3) tick();
    checkVal("rstBusy", 32'(busy), 32'd1);
    checkVal("rstLdReady", 32'(ldReady), 32'd0);
    checkVal("rstRdCount", 32'(rdCount), 32'd0);
    checkVal("rstWrCount", 32'(wrCount), 32'd0);
    checkVal("rstConflict", 32'(conflict), 32'd0);

    // Test 1: clear sweep length and zeroed contents
    rst = 1'b0;
    waitClear(1'b0, n);
    checkVal("clearLen", 32'(n), 32'd256);
    checkVal("readyBusy", 32'(busy), 32'd0);
    checkVal("readyLdReady", 32'(ldReady), 32'd1);
    checkVal("clrRdCount", 32'(rdCount), 32'd0);
    checkVal("clrWrCount", 32'(wrCount), 32'd0);
    for (int a = 0; a < 256; a++) begin
      readChk("zeroRd", 8'(a), 32'h0);
    end

    // Test 2: word write/read and unaligned read
    writeWord(8'h10, 32'h11223344);
    readChk("rd10", 8'h10, 32'h11223344);
    coreBus.mem_read = 1'b1;
    coreBus.mem_addr = 8'h10;
    #1;
    checkVal("rd10Lsb", {24'h0, coreBus.mem_rdata[7:0]}, 32'h00000044);
    tick();
    coreBus.mem_read = 1'b0;
    rdExp++;
    readChk("rd11", 8'h11, 32'h00112233);

    // Test 3: wrap at top of memory
    writeWord(8'hFE, 32'hAABBCCDD);
    readChk("rdFE", 8'hFE, 32'hAABBCCDD);
    readChk("rd00", 8'h00, 32'h0000AABB);
    readChk("rdFF", 8'hFF, 32'h00AABBCC);

    // Test 4: read+write in one cycle
    writeWord(8'h20, 32'h01020304);
    checkVal("preConflict", 32'(conflict), 32'd0);
    coreBus.mem_read  = 1'b1;
    coreBus.mem_write = 1'b1;
    coreBus.mem_addr  = 8'h20;
    coreBus.mem_wdata = 32'hDEADBEEF;
    #1;
    checkVal("rwRdata", coreBus.mem_rdata, 32'h01020304);
    checkVal("rwLdReady", 32'(ldReady), 32'd0);
    tick();
    idle();
    rdExp++;
    wrExp++;
    checkVal("rwConflict", 32'(conflict), 32'd1);
    checkVal("rwRdCount", 32'(rdCount), 32'(rdExp));
    checkVal("rwWrCount", 32'(wrCount), 32'(wrExp));
    readChk("rd20New", 8'h20, 32'hDEADBEEF);
    checkVal("conflictHold", 32'(conflict), 32'd1);

    // Test 5: host load blocked by a core write, accepted next idle cycle
    coreBus.mem_write = 1'b1;
    coreBus.mem_addr  = 8'h40;
    coreBus.mem_wdata = 32'h77665544;
    ldValid = 1'b1;
    ldAddr  = 8'h30;
    ldData  = 8'h5A;
    #1;
    checkVal("ldBlocked", 32'(ldReady), 32'd0);
    tick();
    coreBus.mem_write = 1'b0;
    wrExp++;
    coreBus.mem_read = 1'b1;
    coreBus.mem_addr = 8'h30;
    #1;
    checkVal("ldReadyIdle", 32'(ldReady), 32'd1);
    checkVal("ldDropped", coreBus.mem_rdata, 32'h0);
    tick();
    ldValid = 1'b0;
    coreBus.mem_read = 1'b0;
    rdExp++;
    readChk("ld30", 8'h30, 32'h0000005A);
    readChk("rd40", 8'h40, 32'h77665544);
    checkVal("cntRd", 32'(rdCount), 32'(rdExp));
    checkVal("cntWr", 32'(wrCount), 32'(wrExp));

    // Test 6: reset mid-sweep restarts it; requests while busy are ignored
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (100) tick();
    checkVal("midClearBusy", 32'(busy), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkVal("rst2RdCount", 32'(rdCount), 32'd0);
    checkVal("rst2Conflict", 32'(conflict), 32'd0);
    coreBus.mem_read  = 1'b1;
    coreBus.mem_write = 1'b1;
    coreBus.mem_addr  = 8'h10;
    coreBus.mem_wdata = 32'hFFFFFFFF;
    waitClear(1'b1, n);
    idle();
    rdExp = 0;
    wrExp = 0;
    checkVal("reclearLen", 32'(n), 32'd256);
    checkVal("busyRdCount", 32'(rdCount), 32'd0);
    checkVal("busyWrCount", 32'(wrCount), 32'd0);
    checkVal("busyConflict", 32'(conflict), 32'd0);
    readChk("rd10Cleared", 8'h10, 32'h0);

    // Saturation of the write counter
    coreBus.mem_write = 1'b1;
    coreBus.mem_addr  = 8'h50;
    coreBus.mem_wdata = 32'h12345678;
    repeat (65535) tick();
    checkVal("wrSatReach", 32'(wrCount), 32'h0000FFFF);
    tick();
    coreBus.mem_write = 1'b0;
    checkVal("wrSatHold", 32'(wrCount), 32'h0000FFFF);
    checkVal("satRdCount", 32'(rdCount), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
